// File: rtl/mem_arbiter_if.sv
// Cache-side request/response and RAM-side signals around mem_arbiter.
// master is the arbiter's view; slave is the caches-plus-RAM view.
interface mem_arbiter_if;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    input  dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    output dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output dREN, dWEN, daddr, dstore, iREN, iaddr, ramload, ramstate,
    input  dload, dwait, iload, iwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: shares one RAM port between dcache (priority) and icache (starvation-guarded); MEM_ARB_PERF_EN adds perf counters.
// Latency: one registered arbitration cycle before a grant; completion data is passed straight through from ramload.
// Backpressure: a granted access holds the RAM port until ACCESS; the loser sees wait=1 with its load output held.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_PERF_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.master bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] dgrant_cnt,
  output logic [CNT_W-1:0] igrant_cnt,
  output logic [CNT_W-1:0] istall_cnt
`endif
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_e;

  state_e        state_q, state_d, arb_next;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic [31:0]   dload_q, dload_d, iload_q, iload_d;
  logic          d_req, ram_acc, d_done, i_done;

  always_comb begin
    d_req   = bus.dREN | bus.dWEN;
    ram_acc = (bus.ramstate == RAM_ACCESS);
    d_done  = (state_q == DGRANT) && ram_acc;
    i_done  = (state_q == IGRANT) && ram_acc;

    starve_cnt_d = starve_cnt_q;
    if (d_done) begin
      if (!bus.iREN)
        starve_cnt_d = '0;
      else if (starve_cnt_q != LIMIT)
        starve_cnt_d = starve_cnt_q + SW'(1);
    end else if (i_done) begin
      starve_cnt_d = '0;
    end

    // Uses the post-completion count so the limit-th dcache grant hands over immediately.
    if (d_req && !(bus.iREN && starve_cnt_d == LIMIT))
      arb_next = DGRANT;
    else if (bus.iREN)
      arb_next = IGRANT;
    else
      arb_next = IDLE;

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arb_next;
      DGRANT:  if (d_done) state_d = arb_next;
               else if (!d_req) state_d = IDLE;
      IGRANT:  if (i_done) state_d = arb_next;
      default: state_d = IDLE;
    endcase

    dload_d = d_done ? bus.ramload : dload_q;
    iload_d = i_done ? bus.ramload : iload_q;
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    case (state_q)
      DGRANT: begin
        bus.ramREN   = bus.dREN;
        bus.ramWEN   = bus.dWEN & ~bus.dREN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      default: ;
    endcase
    bus.dwait = ~d_done;
    bus.iwait = ~i_done;
    bus.dload = dload_d;
    bus.iload = iload_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      dload_q      <= '0;
      iload_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dload_q      <= dload_d;
      iload_q      <= iload_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [CNT_W-1:0] dgrant_cnt_q, dgrant_cnt_d;
  logic [CNT_W-1:0] igrant_cnt_q, igrant_cnt_d;
  logic [CNT_W-1:0] istall_cnt_q, istall_cnt_d;

  always_comb begin
    dgrant_cnt_d = dgrant_cnt_q;
    igrant_cnt_d = igrant_cnt_q;
    istall_cnt_d = istall_cnt_q;
    if (d_done && !(&dgrant_cnt_q)) dgrant_cnt_d = dgrant_cnt_q + CNT_W'(1);
    if (i_done && !(&igrant_cnt_q)) igrant_cnt_d = igrant_cnt_q + CNT_W'(1);
    if (bus.iREN && !i_done && !(&istall_cnt_q)) istall_cnt_d = istall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dgrant_cnt_q <= '0;
      igrant_cnt_q <= '0;
      istall_cnt_q <= '0;
    end else begin
      dgrant_cnt_q <= dgrant_cnt_d;
      igrant_cnt_q <= igrant_cnt_d;
      istall_cnt_q <= istall_cnt_d;
    end
  end

  assign dgrant_cnt = dgrant_cnt_q;
  assign igrant_cnt = igrant_cnt_q;
  assign istall_cnt = istall_cnt_q;
`endif
endmodule
